exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; port names and directions SHALL be exactly as listed in REQ-002 to REQ-014.
REQ-002 clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 run  in  1  start/resume request, sampled in IDLE and HALTED.
REQ-005 imem_addr  out  8  program counter presented to instruction memory.
REQ-006 imem_req  out  1  fetch request.
REQ-007 imem_ack  in  1  fetch complete; imem_data valid in the same cycle.
REQ-008 imem_data  in  16  fetched instruction word.
REQ-009 instr  out  16  instruction register, driven to the instruction decoder.
REQ-010 cond_value  in  8  register-file read data for the address in instr[3:0].
REQ-011 wr_strobe  out  1  one-cycle register-file write enable.
REQ-012 halted  out  1  high while in HALTED.
REQ-013 state  out  3  current FSM state encoding.
REQ-014 retired  out  16  retired-instruction count.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC and HALTED; each state SHALL last one cycle unless a wait condition below holds it.
REQ-016 IDLE: the FSM SHALL stay in IDLE while run=0 and SHALL go to FETCH when run=1.
REQ-017 FETCH: imem_req SHALL be 1 and imem_addr SHALL be held stable until imem_ack=1; on that edge imem_data SHALL be latched into instr and the FSM SHALL go to DECODE.
REQ-018 imem_ack outside FETCH SHALL be ignored, and imem_req SHALL be 0 in every state other than FETCH.
REQ-019 DECODE SHALL be a one-cycle register-read settle state with no outputs changing except state, and SHALL go to EXEC.
REQ-020 EXEC: wr_strobe SHALL be 1 for exactly this cycle for opcodes 0x0-0x2 and 0x4-0xB.
REQ-021 EXEC: for opcode 0x3, wr_strobe SHALL be 1 only if cond_value != 0.
REQ-022 EXEC: for opcodes 0xC, 0xD, 0xE and 0xF, wr_strobe SHALL be 0.
REQ-023 EXEC, PC update: opcode 0xD SHALL load the PC with instr[7:0]; every other opcode SHALL set the PC to PC+1 modulo 256 (0xFF wraps to 0x00).
REQ-024 EXEC, next state: opcode 0xE, or opcode 0xF with cond_value != 0, SHALL go to HALTED; every other case SHALL go to FETCH.
REQ-025 Opcode 0xC SHALL execute as a NOP: no write, PC+1.
REQ-026 HALTED: halted SHALL be 1; the FSM SHALL go to FETCH when run=1 and resume at the already-updated PC.
REQ-027 retired SHALL increment by 1 on every EXEC cycle, halts included, and SHALL saturate at 0xFFFF.
REQ-028 A sampled run level in EXEC, FETCH or DECODE SHALL have no effect.

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously set state=IDLE, PC=0x00, instr=0x0000, retired=0, and wr_strobe=imem_req=halted=0.
REQ-030 Reset asserted mid-fetch or mid-EXEC SHALL abort the operation, with no write strobe issued; after rst_n rises the block SHALL wait in IDLE for run.

Configuration
REQ-031 When SINGLE_STEP_EN is defined, the block SHALL add input step (1 bit) and state STEP_WAIT.
REQ-032 With SINGLE_STEP_EN defined, an EXEC that would go to FETCH SHALL go to STEP_WAIT instead; STEP_WAIT SHALL go to FETCH on step=1.
REQ-033 With SINGLE_STEP_EN defined, STEP_WAIT SHALL drive halted=0.
REQ-034 With SINGLE_STEP_EN defined, halts SHALL still go to HALTED.
REQ-035 When SINGLE_STEP_EN is undefined, neither the step port nor the STEP_WAIT state SHALL exist.

Structure
REQ-036 Package seq_pkg SHALL hold the state enum (3-bit) and the opcode constants (OP_SETC=0x0 through OP_CHALT=0xF).
REQ-037 The saturating retired counter SHALL be a sub-module named sat_counter, parameterised by width.

Verification
REQ-038 Reset, then run=1 with imem_ack tied high: imem_addr SHALL read 0x00, then 0x01, then 0x02, one fetch every 3 cycles (FETCH/DECODE/EXEC), and wr_strobe SHALL pulse once per ALU instruction.
REQ-039 Fetch 0xD042 with imem_ack delayed 4 cycles: imem_addr SHALL stay stable and imem_req stay high for those 4 cycles, and the next fetch SHALL be from 0x42.
REQ-040 Opcode 0x3 with cond_value=0x00 SHALL give wr_strobe=0; with cond_value=0x05 it SHALL give wr_strobe=1.
REQ-041 Opcode 0xF with cond_value=0 SHALL continue; with cond_value=0x01 it SHALL assert halted; a run=1 pulse SHALL then resume fetch at the halting PC+1.
REQ-042 PC=0xFF executing 0x4123: the next imem_addr SHALL be 0x00; with retired preloaded near 0xFFFF by 70000 executions, retired SHALL hold 0xFFFF.
REQ-043 rst_n=0 during FETCH with imem_req=1: all outputs SHALL immediately take their reset values, and no wr_strobe SHALL follow.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types and constants for the exec_sequencer block:
//                3-bit FSM state enum, 4-bit opcode constants and small
//                opcode classification helpers.
//                The optional single-step feature (macro SINGLE_STEP_EN)
//                adds the STEP_WAIT state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXEC      = 3'd3,
        ST_HALTED    = 3'd4
`ifdef SINGLE_STEP_EN
        ,
        ST_STEP_WAIT = 3'd5
`endif
    } state_e;

    // Opcode field is instr[15:12].
    localparam logic [3:0] OP_SETC  = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_CWR   = 4'h3;  // write only if cond_value != 0
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_SHL   = 4'h7;
    localparam logic [3:0] OP_SHR   = 4'h8;
    localparam logic [3:0] OP_MOV   = 4'h9;
    localparam logic [3:0] OP_LDI   = 4'hA;
    localparam logic [3:0] OP_INC   = 4'hB;
    localparam logic [3:0] OP_NOP   = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;  // PC <= instr[7:0]
    localparam logic [3:0] OP_HALT  = 4'hE;
    localparam logic [3:0] OP_CHALT = 4'hF;  // halt only if cond_value != 0

    // True when the opcode produces a register-file write in EXEC.
    function automatic logic op_writes(input logic [3:0] op, input logic cond_nz);
        logic wr;
        wr = 1'b0;
        case (op)
            OP_CWR:                          wr = cond_nz;
            OP_NOP, OP_JMP, OP_HALT, OP_CHALT: wr = 1'b0;
            default:                         wr = 1'b1;
        endcase
        return wr;
    endfunction

    // True when the opcode sends the FSM to HALTED after EXEC.
    function automatic logic op_halts(input logic [3:0] op, input logic cond_nz);
        return (op == OP_HALT) || ((op == OP_CHALT) && cond_nz);
    endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at its all-ones value.
//  Ports       : clk      - clock
//                rst_n    - asynchronous active-low reset (count -> 0)
//                inc_i    - increment request for this cycle
//                count_o  - current count
//  Parameters  : WIDTH    - counter width in bits
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exec_sequencer
//  Description : Fetch / decode / execute sequencer. Fetches 16-bit
//                instructions over a req/ack instruction-memory port,
//                issues a one-cycle register-file write strobe in EXEC,
//                handles jumps, conditional writes and (conditional) halts,
//                and counts retired instructions with saturation.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                run              - start from IDLE / resume from HALTED
//                imem_addr/req    - fetch address and request
//                imem_ack/data    - fetch completion and instruction word
//                instr            - instruction register
//                cond_value       - register-file read data for instr[3:0]
//                wr_strobe        - register-file write enable
//                halted           - high in HALTED
//                state            - current FSM state encoding
//                retired          - saturating retired-instruction count
//                step             - (SINGLE_STEP_EN only) leave STEP_WAIT
//  Config      : SINGLE_STEP_EN   - adds step input and STEP_WAIT state
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic [7:0]  imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    input  logic [7:0]  cond_value,
    output logic        wr_strobe,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    state_e      state_q;
    state_e      state_d;
    logic [7:0]  pc_q;
    logic [7:0]  pc_d;
    logic [15:0] instr_q;
    logic [15:0] instr_d;
    logic        retire_inc;

    logic [3:0]  opcode;
    logic        cond_nz;

    assign opcode  = instr_q[15:12];
    assign cond_nz = |cond_value;

    // ------------------------------------------------------------------
    // Next-state and output decode. All outputs are pure functions of the
    // current state (plus instr/cond_value in EXEC), so an asynchronous
    // reset clears them together with state_q.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        imem_req   = 1'b0;
        wr_strobe  = 1'b0;
        halted     = 1'b0;
        retire_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = ST_DECODE;
                end
            end

            // Gives the register file a full cycle to present cond_value
            // for the freshly latched instr[3:0].
            ST_DECODE: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                wr_strobe  = op_writes(opcode, cond_nz);
                retire_inc = 1'b1;
                pc_d       = (opcode == OP_JMP) ? instr_q[7:0] : pc_q + 8'd1;
                if (op_halts(opcode, cond_nz)) begin
                    state_d = ST_HALTED;
                end else begin
`ifdef SINGLE_STEP_EN
                    state_d = ST_STEP_WAIT;
`else
                    state_d = ST_FETCH;
`endif
                end
            end

            // PC already points past the halting instruction.
            ST_HALTED: begin
                halted = 1'b1;
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

`ifdef SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (step) begin
                    state_d = ST_FETCH;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= 8'h00;
            instr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    sat_counter #(
        .WIDTH   (16)
    ) u_retired (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (retire_inc),
        .count_o (retired)
    );

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign state     = state_q;

endmodule : exec_sequencer
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_sequencer
//  Description : Scoreboard bench for exec_sequencer. An architectural model
//                walks the instruction stream and queues the expected fetch
//                address and EXEC behaviour of every instruction; a monitor
//                on the falling edge serves instruction memory and pops and
//                compares. A small sat_counter instance checks saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;
    import seq_pkg::*;

`ifdef SINGLE_STEP_EN
    localparam int STEP_EXTRA = 1;
    logic step = 1'b1;
`else
    localparam int STEP_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [7:0]  cond_value;
    logic        wr_strobe;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] retired;

    logic        sc_inc;
    logic [3:0]  sc_count;

    always #5 clk = ~clk;

    exec_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .instr      (instr),
        .cond_value (cond_value),
        .wr_strobe  (wr_strobe),
        .halted     (halted),
        .state      (state),
        .retired    (retired)
    );

    sat_counter #(.WIDTH(4)) u_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (sc_inc),
        .count_o (sc_count)
    );

    // Register file contents seen through cond_value.
    logic [7:0] rf [16];
    always_comb cond_value = rf[instr[3:0]];

    typedef struct {
        logic [15:0] word;
        int          delay;
        logic [7:0]  addr;
        int          gap;    // expected cycles since previous fetch, 0 = unchecked
    } fetch_t;

    typedef struct {
        logic [15:0] word;
        logic        wr;
        logic        halt;
        logic [15:0] ret;
    } exec_t;

    fetch_t fq[$];
    exec_t  eq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Architectural reference model
    // ------------------------------------------------------------------
    logic [7:0]  m_pc;
    logic [15:0] m_ret;
    bit          m_first;

    task automatic push_instr(input logic [15:0] word, input int delay, output bit halt_o);
        logic [3:0] op;
        logic [7:0] c;
        bit         wr;
        op = word[15:12];
        c  = rf[word[3:0]];
        wr = (op <= 4'h2) || (op >= 4'h4 && op <= 4'hB) || (op == 4'h3 && c != 8'h00);
        halt_o = (op == 4'hE) || (op == 4'hF && c != 8'h00);
        fq.push_back('{word, delay, m_pc, m_first ? 0 : delay + 3 + STEP_EXTRA});
        eq.push_back('{word, wr, halt_o, m_ret});
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
        m_pc    = (op == 4'hD) ? word[7:0] : m_pc + 8'd1;
        m_first = halt_o;
    endtask

    // ------------------------------------------------------------------
    // Monitor + instruction-memory responder
    // ------------------------------------------------------------------
    int         cyc = 0;
    int         delay_cnt = 0;
    int         last_ack = 0;
    bit         pend = 0;
    bit         pend_halt = 0;
    bit         prev_wait = 0;
    bit         underflow_seen = 0;
    logic [7:0] held_addr = 8'h00;

    always @(negedge clk) begin
        fetch_t f;
        exec_t  e;
        cyc++;
        if (!rst_n) begin
            pend      = 0;
            prev_wait = 0;
            delay_cnt = 0;
            imem_ack  = 1'b0;
        end else begin
            if (pend) begin
                check("halt_after_exec", halted, pend_halt);
                pend = 0;
            end
            check("halted_vs_state", halted, state == ST_HALTED);
            check("req_vs_state", imem_req, state == ST_FETCH);
            if (state == ST_EXEC) begin
                if (eq.size() == 0) begin
                    fail("exec_without_expected_instr");
                end else begin
                    e = eq.pop_front();
                    check("instr", instr, e.word);
                    check("wr_strobe", wr_strobe, e.wr);
                    check("retired", retired, e.ret);
                    pend      = 1;
                    pend_halt = e.halt;
                end
            end else begin
                check("no_stray_strobe", wr_strobe, 1'b0);
            end

            if (imem_req) begin
                if (prev_wait) check("addr_stable", imem_addr, held_addr);
                held_addr = imem_addr;
                if (fq.size() == 0) begin
                    if (!underflow_seen) fail("fetch_without_expected_instr");
                    underflow_seen = 1;
                    imem_ack  = 1'b0;
                    prev_wait = 1;
                end else if (delay_cnt < fq[0].delay) begin
                    delay_cnt++;
                    imem_ack  = 1'b0;
                    prev_wait = 1;
                end else begin
                    f = fq.pop_front();
                    check("fetch_addr", imem_addr, f.addr);
                    if (f.gap != 0) check("fetch_gap", cyc - last_ack, f.gap);
                    last_ack  = cyc;
                    imem_ack  = 1'b1;
                    imem_data = f.word;
                    delay_cnt = 0;
                    prev_wait = 0;
                end
            end else begin
                prev_wait = 0;
                imem_ack  = (($urandom % 4) == 0);
                imem_data = 16'($urandom);
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating counter check (4-bit instance)
    // ------------------------------------------------------------------
    initial begin
        sc_inc = 1'b0;
        @(posedge rst_n);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("sat_count", sc_count, (i < 15) ? i : 15);
            sc_inc = 1'b1;
        end
        sc_inc = 1'b0;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic pulse_run();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (halted && eq.size() == 0 && fq.size() == 0) return;
        end
        fail("timeout_waiting_for_halt");
    endtask

    task automatic check_reset_values();
        check("rst_state", state, ST_IDLE);
        check("rst_imem_addr", imem_addr, 8'h00);
        check("rst_instr", instr, 16'h0000);
        check("rst_retired", retired, 16'h0000);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_halted", halted, 1'b0);
    endtask

    initial begin
        bit h;
        rst_n     = 1'b0;
        run       = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        rf[0] = 8'h00;
        rf[1] = 8'h05;
        for (int i = 2; i < 16; i++) begin
            rf[i] = (($urandom % 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        end
        m_pc    = 8'h00;
        m_ret   = 16'h0000;
        m_first = 1;

        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_without_run", state, ST_IDLE);

        // Directed program: ALU run, delayed jump, conditional write,
        // conditional halt, PC wrap, halting CHALT.
        push_instr(16'h1000, 0, h);
        push_instr(16'h2001, 0, h);
        push_instr(16'h5002, 0, h);
        push_instr(16'hD042, 4, h);
        push_instr(16'h3000, 0, h);
        push_instr(16'h3001, 1, h);
        push_instr(16'hF000, 0, h);
        push_instr(16'hC000, 2, h);
        push_instr(16'hD0FF, 0, h);
        push_instr(16'h4123, 0, h);
        push_instr(16'h0000, 0, h);
        push_instr(16'hF001, 0, h);
        pulse_run();
        wait_done();

        // Random segments, each ending in a halt and resumed with run.
        for (int s = 0; s < 30; s++) begin
            h = 0;
            for (int k = 0; k < 20 && !h; k++) begin
                logic [15:0] w;
                w = {4'($urandom_range(0, 15)), 12'($urandom)};
                push_instr(w, (($urandom % 4) == 0) ? int'($urandom_range(1, 5)) : 0, h);
            end
            if (!h) push_instr(16'hE000, 0, h);
            pulse_run();
            wait_done();
        end

        // Reset while a fetch is outstanding.
        push_instr(16'h1000, 10, h);
        pulse_run();
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = imem_req;
            end
            if (!seen) fail("timeout_waiting_for_fetch");
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        fq.delete();
        eq.delete();
        m_pc    = 8'h00;
        m_ret   = 16'h0000;
        m_first = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", state, ST_IDLE);
        check("retired_after_reset", retired, 16'h0000);

        push_instr(16'h2000, 0, h);
        push_instr(16'hE000, 0, h);
        pulse_run();
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_exec_sequencer
`default_nettype wire
